// File: rtl/execute_stage.sv
// EX stage of the 5-stage MIPS pipeline: forwarding, ALU, iterative multiplier.
// Produces the EX/MEM register and stalls upstream while a multiply is in flight.
module execute_stage #(
    parameter int unsigned MUL_STEPS = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [121:0] IDEXReg,
    input  logic [70:0]  MEMWBReg,
    output logic [74:0]  EXMEMReg,
    output logic         stall
);

    localparam int unsigned STEP_BITS = 32 / MUL_STEPS;
    localparam int unsigned CNT_W     = 6;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_MUL = 4'b1000;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, stateNext;

    // ID/EX field decode
    logic [31:0] readData1, readData2, signExtImm;
    logic [4:0]  rs, rt, rd;
    logic        regDst, aluSrc, valid;
    logic [3:0]  aluCtrl;
    logic [3:0]  ctrlBits;

    assign readData1  = IDEXReg[31:0];
    assign readData2  = IDEXReg[63:32];
    assign signExtImm = IDEXReg[95:64];
    assign rs         = IDEXReg[100:96];
    assign rt         = IDEXReg[105:101];
    assign rd         = IDEXReg[110:106];
    assign regDst     = IDEXReg[111];
    assign aluSrc     = IDEXReg[112];
    assign aluCtrl    = IDEXReg[116:113];
    assign ctrlBits   = {IDEXReg[120], IDEXReg[119], IDEXReg[118], IDEXReg[117]};
    assign valid      = IDEXReg[121];

    // Forwarding sources; loads in EX/MEM are excluded (hazard unit bubbles them)
    logic        exFwdOk, wbFwdOk;
    logic [31:0] wbValue;
    logic [31:0] fwdA, fwdRt, opB, aluResult;
    logic [4:0]  writeReg;

    assign exFwdOk = EXMEMReg[74] && !EXMEMReg[72] && (EXMEMReg[68:64] != 5'd0);
    assign wbFwdOk = MEMWBReg[37] && (MEMWBReg[36:32] != 5'd0);
    assign wbValue = MEMWBReg[70] ? MEMWBReg[31:0] : MEMWBReg[69:38];

    always_comb begin
        fwdA = readData1;
        if (exFwdOk && (EXMEMReg[68:64] == rs))
            fwdA = EXMEMReg[31:0];
        else if (wbFwdOk && (MEMWBReg[36:32] == rs))
            fwdA = wbValue;
    end

    always_comb begin
        fwdRt = readData2;
        if (exFwdOk && (EXMEMReg[68:64] == rt))
            fwdRt = EXMEMReg[31:0];
        else if (wbFwdOk && (MEMWBReg[36:32] == rt))
            fwdRt = wbValue;
    end

    assign opB      = aluSrc ? signExtImm : fwdRt;
    assign writeReg = regDst ? rd : rt;

    always_comb begin
        aluResult = 32'd0;
        case (aluCtrl)
            ALU_AND: aluResult = fwdA & opB;
            ALU_OR:  aluResult = fwdA | opB;
            ALU_ADD: aluResult = fwdA + opB;
            ALU_SUB: aluResult = fwdA - opB;
            ALU_NOR: aluResult = ~(fwdA | opB);
            ALU_SLT: aluResult = ($signed(fwdA) < $signed(opB)) ? 32'd1 : 32'd0;
            ALU_SLL: aluResult = opB << signExtImm[10:6];
            default: aluResult = 32'd0;
        endcase
    end

    // Multiplier operands and controls latched at issue
    logic [31:0]      mulAcc, mulMcand, mulMplier, mulPartial;
    logic [CNT_W-1:0] mulCnt;
    logic [4:0]       capReg;
    logic [31:0]      capWData;
    logic [3:0]       capCtrl;
    logic             mulStart, mulStep;
    logic             isMul;
    logic [74:0]      exmemNext;
    logic             stallRaw;

    assign isMul = valid && (aluCtrl == ALU_MUL);

    always_comb begin
        mulPartial = 32'd0;
        for (int j = 0; j < int'(STEP_BITS); j++) begin
            if (mulMplier[j])
                mulPartial = mulPartial + (mulMcand << j);
        end
    end

    always_comb begin
        stateNext = state;
        exmemNext = 75'd0;
        stallRaw  = 1'b0;
        mulStart  = 1'b0;
        mulStep   = 1'b0;
        case (state)
            IDLE: begin
                if (isMul) begin
                    stallRaw  = 1'b1;
                    mulStart  = 1'b1;
                    stateNext = BUSY;
                end else if (valid) begin
                    exmemNext = {ctrlBits, 2'b00, writeReg, fwdRt, aluResult};
                end
            end
            BUSY: begin
                stallRaw = 1'b1;
                mulStep  = 1'b1;
                if (mulCnt == CNT_W'(MUL_STEPS - 1))
                    stateNext = DONE;
            end
            DONE: begin
                exmemNext = {capCtrl, 2'b00, capReg, capWData, mulAcc};
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Held low during reset so upstream is never frozen by a stale MUL in ID/EX
    assign stall = stallRaw && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= stateNext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            EXMEMReg <= 75'd0;
        else
            EXMEMReg <= exmemNext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mulAcc    <= 32'd0;
            mulMcand  <= 32'd0;
            mulMplier <= 32'd0;
            mulCnt    <= CNT_W'(0);
            capReg    <= 5'd0;
            capWData  <= 32'd0;
            capCtrl   <= 4'd0;
        end else if (mulStart) begin
            mulAcc    <= 32'd0;
            mulMcand  <= fwdA;
            mulMplier <= opB;
            mulCnt    <= CNT_W'(0);
            capReg    <= writeReg;
            capWData  <= fwdRt;
            capCtrl   <= ctrlBits;
        end else if (mulStep) begin
            mulAcc    <= mulAcc + mulPartial;
            mulMcand  <= mulMcand << STEP_BITS;
            mulMplier <= mulMplier >> STEP_BITS;
            mulCnt    <= mulCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage (MUL_STEPS = 32).
module tb_execute_stage;

    logic         clk;
    logic         rst_n;
    logic [121:0] IDEXReg;
    logic [70:0]  MEMWBReg;
    logic [74:0]  EXMEMReg;
    logic         stall;

    int nChecks = 0;
    int nFail   = 0;

    localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010,
                           C_SLL = 4'b0011, C_SUB = 4'b0110, C_SLT = 4'b0111,
                           C_MUL = 4'b1000, C_NOR = 4'b1100, C_BAD = 4'b1111;

    execute_stage #(.MUL_STEPS(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .IDEXReg  (IDEXReg),
        .MEMWBReg (MEMWBReg),
        .EXMEMReg (EXMEMReg),
        .stall    (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [121:0] mkId(
        input logic v, input logic rw, input logic mw, input logic m2r, input logic mr,
        input logic [3:0] ctrl, input logic src, input logic dst,
        input logic [4:0] rdI, input logic [4:0] rtI, input logic [4:0] rsI,
        input logic [31:0] imm, input logic [31:0] d2, input logic [31:0] d1);
        return {v, rw, mw, m2r, mr, ctrl, src, dst, rdI, rtI, rsI, imm, d2, d1};
    endfunction

    function automatic logic [70:0] mkWb(
        input logic m2r, input logic [31:0] addr, input logic rw,
        input logic [4:0] wr, input logic [31:0] data);
        return {m2r, addr, rw, wr, data};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [74:0] expWord;
        logic        clean;
        rst_n    = 1'b0;
        IDEXReg  = '0;
        MEMWBReg = '0;
        #3;
        nChecks++;
        if (EXMEMReg !== 75'd0 || stall !== 1'b0) begin
            nFail++;
            $display("FAIL reset_init: EXMEMReg=%h stall=%b, want 0/0", EXMEMReg, stall);
        end
        rst_n = 1'b1;
        tick();
        // start a multiply, then kill it with reset while BUSY
        IDEXReg = mkId(1, 1, 0, 0, 0, C_MUL, 0, 1, 5'd9, 5'd2, 5'd1, 32'd0, 32'd3, 32'd4);
        #1;
        nChecks++;
        if (stall !== 1'b1) begin
            nFail++;
            $display("FAIL mul_issue_stall: stall=%b want 1", stall);
        end
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        nChecks++;
        if (EXMEMReg !== 75'd0 || stall !== 1'b0) begin
            nFail++;
            $display("FAIL reset_midmul: EXMEMReg=%h stall=%b, want 0/0", EXMEMReg, stall);
        end
        IDEXReg = mkId(1, 1, 0, 0, 0, C_ADD, 0, 1, 5'd3, 5'd2, 5'd1, 32'd0, 32'd7, 32'd5);
        #2;
        rst_n = 1'b1;
        tick();
        expWord = {4'b1000, 2'b00, 5'd3, 32'd7, 32'd12};
        nChecks++;
        if (EXMEMReg !== expWord) begin
            nFail++;
            $display("FAIL reset_add: EXMEMReg=%h want %h", EXMEMReg, expWord);
        end
        IDEXReg = '0;
        clean = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (EXMEMReg !== 75'd0 || stall !== 1'b0) clean = 1'b0;
        end
        nChecks++;
        if (!clean) begin
            nFail++;
            $display("FAIL reset_no_stale: output not quiet after aborted MUL, last EXMEMReg=%h", EXMEMReg);
        end
    endtask

    task automatic test_alu_sweep();
        logic [3:0]  ctrls [6];
        logic [31:0] exps  [6];
        ctrls = '{C_ADD, C_SUB, C_SLT, C_NOR, C_OR, C_BAD};
        exps  = '{32'h00000001, 32'hFFFFFFFB, 32'h00000001, 32'h00000000,
                  32'hFFFFFFFF, 32'h00000000};
        MEMWBReg = '0;
        for (int i = 0; i < 6; i++) begin
            IDEXReg = mkId(1, 0, 0, 0, 0, ctrls[i], 0, 0, 5'd0, 5'd2, 5'd1,
                           32'd0, 32'd3, 32'hFFFFFFFE);
            tick();
            nChecks++;
            if (EXMEMReg[31:0] !== exps[i]) begin
                nFail++;
                $display("FAIL alu_%b: result=%h want %h", ctrls[i], EXMEMReg[31:0], exps[i]);
            end
        end
        IDEXReg = mkId(1, 0, 0, 0, 0, C_SLL, 1, 0, 5'd0, 5'd2, 5'd1,
                       32'h00000080, 32'd3, 32'hFFFFFFFE);
        tick();
        nChecks++;
        if (EXMEMReg[31:0] !== 32'h00000200) begin
            nFail++;
            $display("FAIL alu_sll: result=%h want 00000200", EXMEMReg[31:0]);
        end
    endtask

    task automatic test_forward_priority();
        IDEXReg  = '0;
        MEMWBReg = '0;
        tick();
        // EX/MEM gets R5=0x10 while MEM/WB also writes R5=0x20
        IDEXReg  = mkId(1, 1, 0, 0, 0, C_ADD, 0, 1, 5'd5, 5'd0, 5'd0, 32'd0, 32'd0, 32'h10);
        MEMWBReg = mkWb(0, 32'h20, 1, 5'd5, 32'h0);
        tick();
        IDEXReg = mkId(1, 0, 0, 0, 0, C_ADD, 0, 1, 5'd6, 5'd0, 5'd5, 32'd0, 32'd0, 32'h999);
        tick();
        nChecks++;
        if (EXMEMReg[31:0] !== 32'h10) begin
            nFail++;
            $display("FAIL fwd_exmem_priority: A=%h want 00000010", EXMEMReg[31:0]);
        end
        // previous result had RegWrite=0, so only MEM/WB matches now
        tick();
        nChecks++;
        if (EXMEMReg[31:0] !== 32'h20) begin
            nFail++;
            $display("FAIL fwd_memwb_addr: A=%h want 00000020", EXMEMReg[31:0]);
        end
        IDEXReg  = mkId(1, 1, 0, 0, 0, C_ADD, 0, 1, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'h10);
        MEMWBReg = mkWb(0, 32'h20, 1, 5'd0, 32'h0);
        tick();
        IDEXReg = mkId(1, 0, 0, 0, 0, C_ADD, 0, 1, 5'd6, 5'd0, 5'd0, 32'd0, 32'd0, 32'h777);
        tick();
        nChecks++;
        if (EXMEMReg[31:0] !== 32'h777) begin
            nFail++;
            $display("FAIL fwd_r0: A=%h want 00000777", EXMEMReg[31:0]);
        end
        // load in EX/MEM writing R5 is not a forwarding source
        MEMWBReg = '0;
        IDEXReg  = mkId(1, 1, 0, 1, 1, C_ADD, 0, 1, 5'd5, 5'd0, 5'd0, 32'd0, 32'd0, 32'h44);
        tick();
        IDEXReg = mkId(1, 0, 0, 0, 0, C_ADD, 0, 1, 5'd6, 5'd0, 5'd5, 32'd0, 32'd0, 32'h123);
        tick();
        nChecks++;
        if (EXMEMReg[31:0] !== 32'h123) begin
            nFail++;
            $display("FAIL fwd_load_excluded: A=%h want 00000123", EXMEMReg[31:0]);
        end
    endtask

    task automatic test_memwb_forward();
        IDEXReg  = '0;
        MEMWBReg = '0;
        tick();
        MEMWBReg = mkWb(1, 32'h5555, 1, 5'd8, 32'hABCD);
        IDEXReg  = mkId(1, 0, 1, 0, 0, C_AND, 0, 0, 5'd12, 5'd8, 5'd1,
                        32'd0, 32'h1111, 32'hFFFFFFFF);
        tick();
        nChecks++;
        if (EXMEMReg[63:32] !== 32'hABCD || EXMEMReg[68:64] !== 5'd8) begin
            nFail++;
            $display("FAIL memwb_fwd: WriteData=%h WriteReg=%0d want 0000abcd/8",
                     EXMEMReg[63:32], EXMEMReg[68:64]);
        end
        nChecks++;
        if (EXMEMReg[31:0] !== 32'hABCD || EXMEMReg[74:71] !== 4'b0100) begin
            nFail++;
            $display("FAIL memwb_fwd_opb: result=%h ctrl=%b want 0000abcd/0100",
                     EXMEMReg[31:0], EXMEMReg[74:71]);
        end
        MEMWBReg = '0;
    endtask

    task automatic test_mul();
        int   stallCnt;
        logic bubblesOk;
        logic finished;
        IDEXReg  = '0;
        MEMWBReg = '0;
        tick();
        IDEXReg   = mkId(1, 1, 0, 0, 0, C_MUL, 0, 1, 5'd9, 5'd2, 5'd1,
                         32'd0, 32'h00000005, 32'h00010003);
        stallCnt  = 0;
        bubblesOk = 1'b1;
        finished  = 1'b0;
        for (int i = 0; i < 100 && !finished; i++) begin
            #1;
            if (stall === 1'b1) begin
                stallCnt++;
                tick();
                if (EXMEMReg !== 75'd0) bubblesOk = 1'b0;
            end else begin
                finished = 1'b1;
            end
        end
        // upstream advances on the DONE edge
        IDEXReg = '0;
        tick();
        nChecks++;
        if (!finished || stallCnt != 33) begin
            nFail++;
            $display("FAIL mul_stall_len: stall cycles=%0d want 33 (ended=%b)", stallCnt, finished);
        end
        nChecks++;
        if (!bubblesOk) begin
            nFail++;
            $display("FAIL mul_bubbles: nonzero EXMEMReg during stall, got %h want 0", EXMEMReg);
        end
        nChecks++;
        if (EXMEMReg[31:0] !== 32'h0005000F || EXMEMReg[74] !== 1'b1 || EXMEMReg[68:64] !== 5'd9) begin
            nFail++;
            $display("FAIL mul_result: result=%h RegWrite=%b WriteReg=%0d want 0005000f/1/9",
                     EXMEMReg[31:0], EXMEMReg[74], EXMEMReg[68:64]);
        end
        tick();
        nChecks++;
        if (EXMEMReg !== 75'd0) begin
            nFail++;
            $display("FAIL mul_after: EXMEMReg=%h want 0", EXMEMReg);
        end
    endtask

    task automatic test_bubble();
        IDEXReg = mkId(0, 1, 1, 1, 1, C_MUL, 1, 1, 5'd7, 5'd6, 5'd5,
                       32'h1234, 32'hDEAD, 32'hBEEF);
        #1;
        nChecks++;
        if (stall !== 1'b0) begin
            nFail++;
            $display("FAIL bubble_stall: stall=%b want 0", stall);
        end
        tick();
        nChecks++;
        if (EXMEMReg !== 75'd0 || stall !== 1'b0) begin
            nFail++;
            $display("FAIL bubble: EXMEMReg=%h stall=%b want 0/0", EXMEMReg, stall);
        end
        IDEXReg = '0;
    endtask

    initial begin
        test_reset();
        test_alu_sweep();
        test_forward_priority();
        test_memwb_forward();
        test_mul();
        test_bubble();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage MIPS pipeline. Sits between the ID/EX register and the memory stage, and produces the 75-bit EXMEMReg that the memory stage consumes.
- Performs ALU ops and an iterative multi-cycle multiply.
- Resolves RAW hazards by forwarding from its own EX/MEM register and from the fed-back MEMWBReg.
- Stalls upstream while the multiplier is busy.

Parameters:
- MUL_STEPS, 32, number of busy cycles per multiply. Processes 32/MUL_STEPS multiplier bits per cycle. Legal values: 32, 16, 8.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- IDEXReg  input  122  ID/EX bundle:
  - [31:0] ReadData1, [63:32] ReadData2, [95:64] SignExtImm.
  - [100:96] Rs, [105:101] Rt, [110:106] Rd.
  - [111] RegDst, [112] ALUSrc, [116:113] ALUCtrl.
  - [117] MemRead, [118] MemToReg, [119] MemWrite, [120] RegWrite, [121] Valid.
- MEMWBReg  input  71  fed back from memory stage:
  - [70] MemToReg, [69:38] memoryAddress, [37] RegWrite, [36:32] WriteRegister, [31:0] rdData.
- EXMEMReg  output reg 75  to memory stage:
  - [31:0] ALU result, [63:32] WriteData, [68:64] WriteReg, [70:69] zero.
  - [71] MemRead, [72] MemToReg, [73] MemWrite, [74] RegWrite.
- stall  output  1  high = upstream must hold IDEXReg unchanged next edge.

Behaviour:
- Reset (rst_n low, async): EXMEMReg=0, FSM=IDLE, multiplier regs cleared, stall=0. Reset mid-multiply aborts it; no result is ever emitted.
- Forwarding of operand A (Rs) and Rt value; identical logic for each:
  - Priority 1, EX/MEM: EXMEMReg[74]=1, EXMEMReg[72]=0, EXMEMReg[68:64]!=0 and equal to the source register → EXMEMReg[31:0].
  - Priority 2, MEM/WB: MEMWBReg[37]=1, MEMWBReg[36:32]!=0 and equal to the source register → MemToReg ? rdData : memoryAddress.
  - Otherwise: ReadData1 for A, ReadData2 for Rt.
  - Load-use from EX/MEM is not forwarded; the upstream hazard unit inserts the bubble.
- Operand B = ALUSrc ? SignExtImm : forwarded Rt. WriteData = forwarded Rt. WriteReg = RegDst ? Rd : Rt.
- ALUCtrl encodings (result is 32 bits, wraps, no overflow flag):
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR.
  - 0111 SLT: signed compare, result 1 or 0.
  - 0011 SLL: B << SignExtImm[10:6].
  - 1000 MUL: low 32 bits of the unsigned product, multi-cycle.
  - Any other code: result 0.
- FSM states:
  - IDLE, Valid=0: EXMEMReg ← 0 (bubble).
  - IDLE, Valid=1, non-MUL: EXMEMReg ← {RegWrite, MemWrite, MemToReg, MemRead, 2'b00, WriteReg, WriteData, result}. Single-cycle latency.
  - IDLE, Valid=1, ALUCtrl=1000: stall=1 combinationally. Capture forwarded A, B, WriteReg and control bits; clear accumulator. EXMEMReg ← 0. Next state BUSY.
  - BUSY: stall=1. Each cycle add shifted partial products for 32/MUL_STEPS bits. EXMEMReg ← 0. After MUL_STEPS cycles go to DONE.
  - DONE: stall=0. EXMEMReg ← captured controls plus product. Next state IDLE; upstream advances on the same edge.
- MUL latency: issue cycle T; stall high T..T+MUL_STEPS; result in EXMEMReg after the edge ending cycle T+MUL_STEPS+1.
- Operands are latched at issue, so MEMWBReg changes during BUSY do not affect the product.
- EXMEMReg updates every rising edge and is never held; the downstream stage never stalls.

Test Plan:
- Reset: assert rst_n=0 mid-MUL (BUSY). Required: EXMEMReg=0 and stall=0 immediately. After release, an ADD of 5+7 yields EXMEMReg[31:0]=12 one edge later, with no stale product.
- ALU sweep, Valid=1, ReadData1=0xFFFFFFFE, ReadData2=3, no forwarding:
  - ADD → 0x00000001.
  - SUB → 0xFFFFFFFB.
  - SLT → 1.
  - NOR → 0x00000000.
  - SLL with ALUSrc=1, imm=0x00000080, shift=2 → 0x00000200.
- Forward priority: EX/MEM writes R5=0x10 (non-load) while MEMWB writes R5=0x20 and Rs=5. Required: A=0x10. Same case with destination R0: no forward, A=ReadData1.
- MEM/WB forward: MEMWB MemToReg=1, rdData=0xABCD, reg 8, Rt=8, RegDst=0. Required: WriteData=0xABCD and WriteReg=8.
- MUL: 0x00010003 × 0x00000005 with MUL_STEPS=32. Required: stall high exactly 33 cycles, EXMEMReg bubbles during the stall, then EXMEMReg[31:0]=0x0005000F with RegWrite passed through.
- Bubble: Valid=0 with nonzero fields. Required: EXMEMReg=0 and stall=0.
